// File: rtl/bitrev_pkg.sv
// Shared types, default geometry and index helper for the bit-reversal reorder buffer.
package bitrev_pkg;

  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_LOG_N     = 6;
  localparam int unsigned DEF_LOG_LANES = 2;
  localparam int unsigned N             = 1 << DEF_LOG_N;
  localparam int unsigned LANES         = 1 << DEF_LOG_LANES;
  localparam int unsigned BEATS         = N / LANES;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  // Reverse the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned nbits);
    logic [31:0] rev;
    rev = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(nbits)) rev[i] = idx[int'(nbits) - 1 - i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/bitrev_pingpong_ctrl.sv
// Ping-pong bank sequencing: bank states, beat counters, handshakes and framing check.
module bitrev_pingpong_ctrl
  import bitrev_pkg::*;
#(
  parameter int unsigned BEAT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic              frame_err,
  output logic              wr_en_c,
  output logic              wr_bank_c,
  output logic [BEAT_W-1:0] wr_beat_c,
  output logic              rd_load_c,
  output logic              rd_bank_c,
  output logic [BEAT_W-1:0] rd_beat_c
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = '1;

  bank_state_e       bank_q [2];
  bank_state_e       bank_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [BEAT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [BEAT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_err_q, frame_err_d;
  logic              wr_fire, wr_final, rd_hs, rd_release, rd_load, cand;

  always_comb begin
    bank_d      = bank_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_load     = 1'b0;
    cand        = rd_bank_q;
    wr_fire     = in_valid && in_ready_q;
    wr_final    = wr_fire && (wr_cnt_q == LAST_BEAT);
    rd_hs       = out_valid_q && out_ready;
    rd_release  = rd_hs && (rd_cnt_q == LAST_BEAT);
    frame_err_d = wr_fire && (in_last != (wr_cnt_q == LAST_BEAT));

    if (wr_fire) begin
      wr_cnt_d          = wr_final ? '0 : wr_cnt_q + 1'b1;
      wr_bank_d         = wr_final ? ~wr_bank_q : wr_bank_q;
      bank_d[wr_bank_q] = wr_final ? FULL : FILLING;
    end

    if (rd_release) bank_d[rd_bank_q] = EMPTY;

    // Next output beat: continue the current bank, or start the next complete
    // bank (including one whose final beat is being written this very cycle).
    if (rd_hs && !rd_release) begin
      rd_load  = 1'b1;
      rd_cnt_d = rd_cnt_q + 1'b1;
    end else if (!out_valid_q || rd_release) begin
      cand      = out_valid_q ? ~rd_bank_q : rd_bank_q;
      rd_bank_d = cand;
      if ((bank_q[cand] == FULL) || (wr_final && (wr_bank_q == cand))) begin
        rd_load      = 1'b1;
        rd_cnt_d     = '0;
        bank_d[cand] = DRAINING;
      end
    end

    out_valid_d = rd_load || (out_valid_q && !out_ready);
    out_last_d  = rd_load ? (rd_cnt_d == LAST_BEAT) : (out_last_q && out_valid_d);
    in_ready_d  = (bank_d[wr_bank_d] == EMPTY) || (bank_d[wr_bank_d] == FILLING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q[0]   <= EMPTY;
      bank_q[1]   <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;
  assign wr_en_c   = wr_fire;
  assign wr_bank_c = wr_bank_q;
  assign wr_beat_c = wr_cnt_q;
  assign rd_load_c = rd_load;
  assign rd_bank_c = rd_bank_d;
  assign rd_beat_c = rd_cnt_d;

endmodule

// File: rtl/bitrev_reorder_buf.sv
// Streaming bit-reversal reorder buffer with ping-pong frame storage.
// Optional BITREV_MODE_EN adds in_mode: per-frame natural-order pass-through.
module bitrev_reorder_buf
  import bitrev_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned LOG_N     = DEF_LOG_N,
  parameter int unsigned LOG_LANES = DEF_LOG_LANES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(1<<LOG_LANES)*DATA_W-1:0] in_data,
`ifdef BITREV_MODE_EN
  input  logic                        in_mode,
`endif
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [(1<<LOG_LANES)*DATA_W-1:0] out_data,
  output logic                        out_last,
  output logic                        frame_err
);

  localparam int unsigned FRAME_N   = 1 << LOG_N;
  localparam int unsigned NUM_LANES = 1 << LOG_LANES;
  localparam int unsigned BEAT_W    = LOG_N - LOG_LANES;

  logic [DATA_W-1:0]           mem_q [2*FRAME_N];
  logic [DATA_W-1:0]           mem_d [2*FRAME_N];
  logic [NUM_LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic                        wr_en_c, wr_bank_c, rd_load_c, rd_bank_c, rd_mode;
  logic [BEAT_W-1:0]           wr_beat_c, rd_beat_c;
  logic [LOG_N-1:0]            nat_idx, src_idx;

  bitrev_pingpong_ctrl #(.BEAT_W(BEAT_W)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .frame_err (frame_err),
    .wr_en_c   (wr_en_c),
    .wr_bank_c (wr_bank_c),
    .wr_beat_c (wr_beat_c),
    .rd_load_c (rd_load_c),
    .rd_bank_c (rd_bank_c),
    .rd_beat_c (rd_beat_c)
  );

`ifdef BITREV_MODE_EN
  logic mode_q [2];
  logic mode_d [2];

  // Mode is captured with the first beat of a frame and travels with its bank.
  always_comb begin
    mode_d = mode_q;
    if (wr_en_c && (wr_beat_c == '0)) mode_d[wr_bank_c] = in_mode;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q[0] <= 1'b0;
      mode_q[1] <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign rd_mode = mode_q[rd_bank_c];
`else
  assign rd_mode = 1'b0;
`endif

  always_comb begin
    mem_d = mem_q;
    if (wr_en_c) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        mem_d[{wr_bank_c, wr_beat_c, LOG_LANES'(l)}] = in_data[DATA_W*l +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Output beat gather; words from the beat being written now are forwarded
  // straight from in_data so a bank can start draining on its completing edge.
  always_comb begin
    out_data_d = out_data_q;
    nat_idx    = '0;
    src_idx    = '0;
    if (rd_load_c) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        nat_idx = {rd_beat_c, LOG_LANES'(l)};
        src_idx = rd_mode ? nat_idx : LOG_N'(bitrev(32'(nat_idx), LOG_N));
        if (wr_en_c && (wr_bank_c == rd_bank_c) && (src_idx[LOG_N-1:LOG_LANES] == wr_beat_c)) begin
          out_data_d[DATA_W*l +: DATA_W] = in_data[DATA_W*int'(src_idx[LOG_LANES-1:0]) +: DATA_W];
        end else begin
          out_data_d[DATA_W*l +: DATA_W] = mem_q[{rd_bank_c, src_idx}];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) out_data_q <= '0;
    else       out_data_q <= out_data_d;
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Directed self-checking bench for bitrev_reorder_buf (DATA_W=8, LOG_N=4, LOG_LANES=1).
module tb_bitrev_reorder_buf;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        frame_err;
`ifdef BITREV_MODE_EN
  logic        in_mode;
`endif

  int rev4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int n_checks   = 0;
  int n_errors   = 0;
  int err_pulses = 0;
  int s, r, cyc;

  bitrev_reorder_buf #(.DATA_W(8), .LOG_N(4), .LOG_LANES(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef BITREV_MODE_EN
    .in_mode   (in_mode),
`endif
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] nat_beat(input int base, input int b);
    return {8'(base + 2*b + 1), 8'(base + 2*b)};
  endfunction

  function automatic logic [15:0] rev_beat(input int base, input int j);
    return {8'(base + rev4[2*j+1]), 8'(base + rev4[2*j])};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (frame_err) err_pulses++;
  endtask

  task automatic send_frame(input int base, input int err_beat);
    int w;
    for (int b = 0; b < 8; b++) begin
      in_valid = 1'b1;
      in_data  = nat_beat(base, b);
      in_last  = (b == 7) || (b == err_beat);
      w = 0;
      while (!in_ready && w < 20) begin
        tick();
        w++;
      end
      chk($sformatf("send_in_ready_b%0d", b), 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain_frame(input int base, input logic natural, input string tag);
    int w;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      w = 0;
      while (!out_valid && w < 20) begin
        tick();
        w++;
      end
      chk($sformatf("%s_valid_b%0d", tag, j), 32'(out_valid), 32'd1);
      chk($sformatf("%s_data_b%0d", tag, j), 32'(out_data),
          natural ? 32'(nat_beat(base, j)) : 32'(rev_beat(base, j)));
      chk($sformatf("%s_last_b%0d", tag, j), 32'(out_last), 32'(j == 7));
      tick();
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef BITREV_MODE_EN
    in_mode   = 1'b0;
`endif
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_in_ready_after", 32'(in_ready), 32'd1);

    // Single frame: latency and bit-reversed order.
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      in_valid = 1'b1;
      in_data  = nat_beat(0, b);
      in_last  = (b == 7);
      chk($sformatf("t1_in_ready_b%0d", b), 32'(in_ready), 32'd1);
      chk($sformatf("t1_no_early_valid_b%0d", b), 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t1_latency_valid", 32'(out_valid), 32'd1);
    chk("t1_beat0", 32'(out_data), 32'h0800);
    drain_frame(0, 1'b0, "t1");
    chk("t1_idle", 32'(out_valid), 32'd0);

    // Three frames back to back: no bubbles, each frame reversed.
    s = 0; r = 0; cyc = 0;
    out_ready = 1'b1;
    while (r < 24 && cyc < 200) begin
      if (s < 24) begin
        in_valid = 1'b1;
        in_data  = nat_beat(16*(s/8), s%8);
        in_last  = (s%8 == 7);
        chk("t2_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (r > 0) chk("t2_out_bubble", 32'(out_valid), 32'd1);
      if (out_valid) begin
        chk($sformatf("t2_data_r%0d", r), 32'(out_data), 32'(rev_beat(16*(r/8), r%8)));
        chk($sformatf("t2_last_r%0d", r), 32'(out_last), 32'(r%8 == 7));
        r++;
      end
      if (in_valid && in_ready) s++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t2_all_beats", 32'(r), 32'd24);

    // Backpressure: two frames stored, third blocked, output held.
    out_ready = 1'b0;
    s = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid = 1'b1;
      in_data  = nat_beat(16*(s/8), s%8);
      in_last  = (s%8 == 7);
      if (in_ready) s++;
      tick();
      if (out_valid) chk("t3_hold", 32'(out_data), 32'h0800);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t3_accepted",     32'(s),         32'd16);
    chk("t3_in_ready_low", 32'(in_ready),  32'd0);
    chk("t3_out_valid",    32'(out_valid), 32'd1);
    chk("t3_out_data",     32'(out_data),  32'h0800);
    drain_frame(0, 1'b0, "t3a");
    drain_frame(16, 1'b0, "t3b");

    // Early in_last on beat 3: single error pulse, frame still complete.
    err_pulses = 0;
    send_frame(0, 3);
    drain_frame(0, 1'b0, "t4");
    chk("t4_err_pulses", 32'(err_pulses), 32'd1);

    // Reset mid-frame discards the partial frame.
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      in_data  = nat_beat(48, b);
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready",  32'(in_ready),  32'd0);
    chk("t5_out_data",  32'(out_data),  32'd0);
    chk("t5_out_last",  32'(out_last),  32'd0);
    chk("t5_frame_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    tick();
    chk("t5_in_ready_after", 32'(in_ready), 32'd1);
    send_frame(0, -1);
    drain_frame(0, 1'b0, "t5");

`ifdef BITREV_MODE_EN
    // Natural-order frame followed by a reversed frame.
    in_mode = 1'b1;
    send_frame(0, -1);
    drain_frame(0, 1'b1, "t6a");
    in_mode = 1'b0;
    send_frame(0, -1);
    drain_frame(0, 1'b0, "t6b");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
